// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with a valid/ready output.
// Build option: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit. PARITY_ODD selects odd (1) or even (0) parity.
// Without the macro, frames are start + DATA_BITS + stop and parity_err is 0.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q;
    logic                 rxs_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 deliver_q, deliver_d;
    logic                 frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 par_ok;
    logic                 tick;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_INV = (PARITY_ODD != 0);
    logic par_ok_q, par_ok_d;
    logic parity_err_q, parity_err_d;
    assign par_ok     = par_ok_q;
    assign parity_err = parity_err_q;
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    // Sample point for every bit after the start bit: last count of a full bit period.
    assign tick = (cnt_q == FULL_M1);

    // Frame FSM next state: bit timing, data shifting, stop/parity evaluation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        deliver_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d     = par_ok_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rxs_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    cnt_d    = '0;
                    par_ok_d = (rxs_q == ((^shift_q) ^ PAR_INV));
                    state_d  = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = !par_ok;
`endif
                    if (rxs_q) begin
                        deliver_d = par_ok;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output holding register: load on delivery, clear on consumption, flag a drop.
    always_comb begin
        data_d       = data_q;
        data_valid_d = data_valid_q;
        overrun_d    = 1'b0;
        if (data_valid_q && data_ready) data_valid_d = 1'b0;
        if (deliver_q) begin
            if (!data_valid_q || data_ready) begin
                data_d       = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // All state: synchronizer idles high so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            deliver_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok_q     <= 1'b1;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q      <= rxd;
            rxs_q        <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            deliver_q    <= deliver_d;
            frame_err_q  <= frame_err_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_ok_q     <= par_ok_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param (CLKS_PER_BIT=16, DATA_BITS=8, even parity).
// Frames are built from the line-format rules; received words, error pulses
// and overruns are collected by a monitor and compared against expectations.
module tb_uart_rx_param;

    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       data_ready = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    // Monitor on the falling edge: count pulses and record consumed words.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err)  fe_cnt++;
            if (parity_err) pe_cnt++;
            if (overrun)    ov_cnt++;
            if (data_valid && data_ready) rx_q.push_back(data);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line model: start, LSB-first data, optional parity, stop; rxd left at stop level.
    task automatic send_frame(input logic [7:0] w, input logic stop_b, input logic flip_par);
        rxd = 1'b0;
        step(CPB);
        for (int i = 0; i < DB; i++) begin
            rxd = w[i];
            step(CPB);
        end
        if (PB != 0) begin
            rxd = (^w) ^ (PODD != 0) ^ flip_par;
            step(CPB);
        end
        rxd = stop_b;
        step(CPB);
    endtask

    task automatic wait_word(output logic got, output logic [7:0] w);
        got = 1'b0;
        w   = 8'h00;
        for (int k = 0; k < 400 && !got; k++) begin
            if (rx_q.size() > 0) begin
                w   = rx_q.pop_front();
                got = 1'b1;
            end else begin
                step(1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        data_ready = 1'b1;
        step(3);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        rst = 1'b0;
        step(5);
    endtask

    task automatic test_latency();
        int lat;
        int exp_lat;
        int fe0, pe0, ov0;
        logic got;
        logic [7:0] w;
        // Edges after the fall: 2 synchronizer, 1 to leave IDLE, half a bit to
        // the start sample, full bits to the stop sample, 1 registered delivery.
        exp_lat = 3 + CPB / 2 + (1 + DB + PB) * CPB + 1;
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        lat = -1;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                for (int k = 1; k <= 300; k++) begin
                    step(1);
                    if (data_valid && lat < 0) lat = k;
                end
            end
        join
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL latency: got %0d expected %0d", lat, exp_lat); end
        wait_word(got, w);
        checks++; if (!got || w !== 8'hA5) begin errors++; $display("FAIL word_a5: got %h (seen=%b) expected a5", w, got); end
        checks++; if ((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0) != 0) begin
            errors++; $display("FAIL a5_errors: got fe=%0d pe=%0d ov=%0d expected 0", fe_cnt - fe0, pe_cnt - pe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_glitch();
        int fe0, pe0, ov0;
        logic got;
        logic [7:0] w, exp_w;
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        rxd = 1'b0;
        step(5);
        rxd = 1'b1;
        step(40);
        checks++; if (rx_q.size() != 0 || data_valid !== 1'b0) begin
            errors++; $display("FAIL glitch_no_data: got words=%0d valid=%b expected 0", rx_q.size(), data_valid);
        end
        checks++; if ((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0) != 0) begin
            errors++; $display("FAIL glitch_errors: got fe=%0d pe=%0d ov=%0d expected 0", fe_cnt - fe0, pe_cnt - pe0, ov_cnt - ov0);
        end
        exp_w = 8'($urandom);
        send_frame(exp_w, 1'b1, 1'b0);
        wait_word(got, w);
        checks++; if (!got || w !== exp_w) begin errors++; $display("FAIL glitch_next_word: got %h (seen=%b) expected %h", w, got, exp_w); end
    endtask

    task automatic test_frame_err();
        int fe0, pe0;
        logic got;
        logic [7:0] w;
        fe0 = fe_cnt; pe0 = pe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        step(40);
        rxd = 1'b1;
        step(CPB);
        checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL frame_err_count: got %0d expected 1", fe_cnt - fe0); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL frame_err_no_data: got %0d words expected 0", rx_q.size()); end
        send_frame(8'h11, 1'b1, 1'b0);
        wait_word(got, w);
        checks++; if (!got || w !== 8'h11) begin errors++; $display("FAIL word_11: got %h (seen=%b) expected 11", w, got); end
        checks++; if ((fe_cnt - fe0 != 1) || (pe_cnt != pe0)) begin
            errors++; $display("FAIL frame_err_after: got fe=%0d pe=%0d expected fe=1 pe=0", fe_cnt - fe0, pe_cnt - pe0);
        end
    endtask

    task automatic test_overrun();
        int ov0;
        logic got;
        logic [7:0] w;
        ov0 = ov_cnt;
        data_ready = 1'b0;
        send_frame(8'h01, 1'b1, 1'b0);
        step(4);
        send_frame(8'h02, 1'b1, 1'b0);
        step(8);
        checks++; if (data_valid !== 1'b1 || data !== 8'h01) begin
            errors++; $display("FAIL overrun_hold: got valid=%b data=%h expected 1/01", data_valid, data);
        end
        checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL overrun_count: got %0d expected 1", ov_cnt - ov0); end
        data_ready = 1'b1;
        step(1);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL overrun_release: got valid=%b expected 0", data_valid); end
        wait_word(got, w);
        checks++; if (!got || w !== 8'h01 || rx_q.size() != 0) begin
            errors++; $display("FAIL overrun_word: got %h (seen=%b, extra=%0d) expected 01 only", w, got, rx_q.size());
        end
    endtask

    task automatic test_parity();
        int pe0, fe0;
        logic got;
        logic [7:0] w;
        pe0 = pe_cnt; fe0 = fe_cnt;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        step(CPB);
        checks++; if (pe_cnt - pe0 != 1 || fe_cnt != fe0) begin
            errors++; $display("FAIL parity_bad: got pe=%0d fe=%0d expected pe=1 fe=0", pe_cnt - pe0, fe_cnt - fe0);
        end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL parity_bad_data: got %0d words expected 0", rx_q.size()); end
        send_frame(8'h07, 1'b1, 1'b0);
        wait_word(got, w);
        checks++; if (!got || w !== 8'h07) begin errors++; $display("FAIL parity_good: got %h (seen=%b) expected 07", w, got); end
`else
        send_frame(8'h07, 1'b1, 1'b0);
        wait_word(got, w);
        checks++; if (!got || w !== 8'h07) begin errors++; $display("FAIL word_07: got %h (seen=%b) expected 07", w, got); end
        checks++; if (pe_cnt != 0) begin errors++; $display("FAIL parity_tied: got %0d pulses expected 0", pe_cnt); end
`endif
    endtask

    task automatic test_reset_midframe();
        logic got;
        logic [7:0] w;
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                step(CPB + 4 * CPB + CPB / 2);
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
        join
        step(CPB);
        checks++; if (rx_q.size() != 0 || data_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_no_data: got words=%0d valid=%b expected 0", rx_q.size(), data_valid);
        end
        send_frame(8'h55, 1'b1, 1'b0);
        wait_word(got, w);
        checks++; if (!got || w !== 8'h55) begin errors++; $display("FAIL word_55: got %h (seen=%b) expected 55", w, got); end
    endtask

    task automatic test_back_to_back();
        int fe0, pe0, ov0;
        logic got;
        logic [7:0] w, exp_w;
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        data_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            exp_w = 8'($urandom);
            send_frame(exp_w, 1'b1, 1'b0);
            step($urandom_range(0, 20));
            wait_word(got, w);
            checks++; if (!got || w !== exp_w) begin
                errors++; $display("FAIL random_word_%0d: got %h (seen=%b) expected %h", n, w, got, exp_w);
            end
        end
        checks++; if ((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0) != 0) begin
            errors++; $display("FAIL random_errors: got fe=%0d pe=%0d ov=%0d expected 0", fe_cnt - fe0, pe_cnt - pe0, ov_cnt - ov0);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_parity();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
